// File: rtl/otp_pkg.sv
// otp_pkg: shared types and constants for the OTP access arbiter
//   state_t : sequencer states (IDLE, SETUP, STROBE, HOLD)
//   own_t   : transaction owner (boot loader or host)
//   AW_DEF/DW_DEF : default OTP address/data widths
//   TW, tload()   : timing counter width and its reload value for a T-cycle phase
package otp_pkg;

    localparam int AW_DEF = 6;
    localparam int DW_DEF = 8;
    localparam int TW     = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_t;

    typedef enum logic {
        OWN_BOOT,
        OWN_HOST
    } own_t;

    // A phase of T cycles starts at T-1 and ends on the cycle the count reads 0.
    function automatic logic [TW-1:0] tload(input int t);
        return TW'(t - 1);
    endfunction

endpackage

// File: rtl/otp_tmr.sv
// otp_tmr: loadable down-counter that parks at zero and flags it
//   clk   in  clock
//   rst_n in  asynchronous active-low reset (count clears to 0)
//   load  in  load val this cycle
//   val   in  TW  reload value
//   zero  out count is 0
module otp_tmr
    import otp_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [TW-1:0] val,
    output logic          zero
);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = cnt == '0;

endmodule

// File: rtl/otp_arb.sv
// otp_arb: sequences OTP macro reads/programs and shares the macro between boot loader and host
//   CLK, RESET                       clock, asynchronous active-low reset
//   BOOT_REQ/ADDR -> BOOT_RDATA/DONE boot read port (strict priority)
//   HOST_REQ/WR/ADDR/WDATA -> HOST_RDATA/DONE/ERR  host read/program port
//   PROG_UNLOCK                      programming permitted when 1
//   BUSY                             high whenever the sequencer is not idle
//   OTP_CS/READ/PROG/ADDR/DATI, OTP_DATO  registered macro pins and read data
module otp_arb
    import otp_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int T_SETUP = 2,
    parameter int T_RD    = 4,
    parameter int T_PG    = 1000,
    parameter int T_HOLD  = 2
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          BOOT_REQ,
    input  logic [AW-1:0] BOOT_ADDR,
    output logic [DW-1:0] BOOT_RDATA,
    output logic          BOOT_DONE,
    input  logic          HOST_REQ,
    input  logic          HOST_WR,
    input  logic [AW-1:0] HOST_ADDR,
    input  logic [DW-1:0] HOST_WDATA,
    output logic [DW-1:0] HOST_RDATA,
    output logic          HOST_DONE,
    output logic          HOST_ERR,
    input  logic          PROG_UNLOCK,
    output logic          BUSY,
    output logic          OTP_CS,
    output logic          OTP_READ,
    output logic          OTP_PROG,
    output logic [AW-1:0] OTP_ADDR,
    output logic [DW-1:0] OTP_DATI,
    input  logic [DW-1:0] OTP_DATO
);

    state_t        state, state_nxt;
    own_t          own;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt_boot, gnt_host, reject, grant, fin, cap;
    logic          ld, zero;
    logic [TW-1:0] ld_val;

    otp_tmr u_tmr (
        .clk   (CLK),
        .rst_n (RESET),
        .load  (ld),
        .val   (ld_val),
        .zero  (zero)
    );

    // A requester is masked during its own DONE cycle so a REQ held one
    // cycle too long cannot start a second transaction immediately.
    always_comb begin
        gnt_boot = BOOT_REQ && !BOOT_DONE;
        gnt_host = HOST_REQ && !HOST_DONE && !gnt_boot;
        reject   = state == ST_IDLE && gnt_host && HOST_WR && !PROG_UNLOCK;
        grant    = state == ST_IDLE && (gnt_boot || (gnt_host && !(HOST_WR && !PROG_UNLOCK)));
        fin      = state == ST_HOLD && zero;
        cap      = state == ST_STROBE && zero && !wr;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ld        = 1'b0;
        ld_val    = '0;
        case (state)
            ST_IDLE: if (grant) begin
                state_nxt = ST_SETUP;
                ld        = 1'b1;
                ld_val    = tload(T_SETUP);
            end
            ST_SETUP: if (zero) begin
                state_nxt = ST_STROBE;
                ld        = 1'b1;
                ld_val    = wr ? tload(T_PG) : tload(T_RD);
            end
            ST_STROBE: if (zero) begin
                state_nxt = ST_HOLD;
                ld        = 1'b1;
                ld_val    = tload(T_HOLD);
            end
            default: if (zero) state_nxt = ST_IDLE;
        endcase
    end

    // Pins decode the next state so they change on the same edge as the state.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            own        <= OWN_BOOT;
            wr         <= 1'b0;
            addr       <= '0;
            wdata      <= '0;
            OTP_CS     <= 1'b0;
            OTP_READ   <= 1'b0;
            OTP_PROG   <= 1'b0;
            BOOT_DONE  <= 1'b0;
            HOST_DONE  <= 1'b0;
            HOST_ERR   <= 1'b0;
            BOOT_RDATA <= '0;
            HOST_RDATA <= '0;
        end else begin
            OTP_CS    <= state_nxt != ST_IDLE;
            OTP_READ  <= state_nxt == ST_STROBE && !wr;
            OTP_PROG  <= state_nxt == ST_STROBE && wr;
            BOOT_DONE <= fin && own == OWN_BOOT;
            HOST_DONE <= (fin && own == OWN_HOST) || reject;
            HOST_ERR  <= reject;
            if (grant) begin
                own   <= gnt_boot ? OWN_BOOT : OWN_HOST;
                wr    <= gnt_boot ? 1'b0 : HOST_WR;
                addr  <= gnt_boot ? BOOT_ADDR : HOST_ADDR;
                wdata <= gnt_boot ? '0 : HOST_WDATA;
            end
            if (cap && own == OWN_BOOT)
                BOOT_RDATA <= OTP_DATO;
            if (cap && own == OWN_HOST)
                HOST_RDATA <= OTP_DATO;
        end
    end

    assign BUSY     = state != ST_IDLE;
    assign OTP_ADDR = addr;
    assign OTP_DATI = wdata;

endmodule

// File: tb/tb_otp_arb.sv
// tb_otp_arb: directed self-checking bench for otp_arb with a small OTP macro model
module tb_otp_arb;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       BOOT_REQ = 1'b0;
    logic [5:0] BOOT_ADDR = '0;
    logic [7:0] BOOT_RDATA;
    logic       BOOT_DONE;
    logic       HOST_REQ = 1'b0;
    logic       HOST_WR = 1'b0;
    logic [5:0] HOST_ADDR = '0;
    logic [7:0] HOST_WDATA = '0;
    logic [7:0] HOST_RDATA;
    logic       HOST_DONE;
    logic       HOST_ERR;
    logic       PROG_UNLOCK = 1'b0;
    logic       BUSY;
    logic       OTP_CS, OTP_READ, OTP_PROG;
    logic [5:0] OTP_ADDR;
    logic [7:0] OTP_DATI;
    logic [7:0] OTP_DATO;

    always #5 CLK = ~CLK;

    otp_arb dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .BOOT_REQ    (BOOT_REQ),
        .BOOT_ADDR   (BOOT_ADDR),
        .BOOT_RDATA  (BOOT_RDATA),
        .BOOT_DONE   (BOOT_DONE),
        .HOST_REQ    (HOST_REQ),
        .HOST_WR     (HOST_WR),
        .HOST_ADDR   (HOST_ADDR),
        .HOST_WDATA  (HOST_WDATA),
        .HOST_RDATA  (HOST_RDATA),
        .HOST_DONE   (HOST_DONE),
        .HOST_ERR    (HOST_ERR),
        .PROG_UNLOCK (PROG_UNLOCK),
        .BUSY        (BUSY),
        .OTP_CS      (OTP_CS),
        .OTP_READ    (OTP_READ),
        .OTP_PROG    (OTP_PROG),
        .OTP_ADDR    (OTP_ADDR),
        .OTP_DATI    (OTP_DATI),
        .OTP_DATO    (OTP_DATO)
    );

    logic [7:0] mem [64];
    assign OTP_DATO = OTP_READ ? mem[OTP_ADDR] : 8'h00;

    logic [5:0] exp_addr = '0;
    logic [7:0] exp_dati = '0;
    int rd_cnt = 0, pg_cnt = 0, bd_cnt = 0, hd_cnt = 0, cs_cnt = 0, both_cnt = 0, bad_cnt = 0;

    always @(negedge CLK) begin
        if (OTP_READ) rd_cnt++;
        if (OTP_PROG) pg_cnt++;
        if (BOOT_DONE) bd_cnt++;
        if (HOST_DONE) hd_cnt++;
        if (OTP_CS) cs_cnt++;
        if (OTP_READ && OTP_PROG) both_cnt++;
        if (OTP_PROG && (OTP_ADDR !== exp_addr || OTP_DATI !== exp_dati)) bad_cnt++;
    end

    int n_assert = 0, n_fail = 0;
    int b_rd, b_pg, b_bd, b_hd, b_cs, b_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic snap();
        b_rd = rd_cnt; b_pg = pg_cnt; b_bd = bd_cnt; b_hd = hd_cnt; b_cs = cs_cnt; b_bad = bad_cnt;
    endtask

    task automatic wait_done(input bit host, input int lim, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (((host ? HOST_DONE : BOOT_DONE) !== 1'b1) && n < lim);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        mem[6'h03] = 8'hA5;
        mem[6'h07] = 8'h77;
        mem[6'h05] = 8'h5A;
        mem[6'h21] = 8'hC3;

        // reset state
        step();
        step();
        chk("rst_busy", BUSY, 0);
        chk("rst_cs", OTP_CS, 0);
        chk("rst_read", OTP_READ, 0);
        chk("rst_prog", OTP_PROG, 0);
        chk("rst_addr", OTP_ADDR, 0);
        chk("rst_dati", OTP_DATI, 0);
        chk("rst_done", {BOOT_DONE, HOST_DONE, HOST_ERR}, 0);
        chk("rst_rdata", {BOOT_RDATA, HOST_RDATA}, 0);
        RESET = 1'b1;
        step();

        // boot read, request at edge k
        snap();
        BOOT_ADDR = 6'h03;
        BOOT_REQ  = 1'b1;
        step();
        chk("boot_cs_rise", OTP_CS, 1);
        chk("boot_no_strobe_setup", OTP_READ, 0);
        wait_done(1'b0, 20, n);
        chk("boot_latency", n, 8);
        chk("boot_rdata", BOOT_RDATA, 8'hA5);
        chk("boot_cs_fall", OTP_CS, 0);
        chk("boot_idle", BUSY, 0);
        BOOT_REQ = 1'b0;
        step();
        chk("boot_done_pulse", BOOT_DONE, 0);
        chk("boot_read_len", rd_cnt - b_rd, 4);
        chk("boot_done_cnt", bd_cnt - b_bd, 1);
        chk("boot_host_rdata", HOST_RDATA, 0);

        // locked program
        snap();
        HOST_WR     = 1'b1;
        HOST_ADDR   = 6'h10;
        HOST_WDATA  = 8'h3C;
        PROG_UNLOCK = 1'b0;
        HOST_REQ    = 1'b1;
        step();
        chk("lock_done", HOST_DONE, 1);
        chk("lock_err", HOST_ERR, 1);
        chk("lock_busy", BUSY, 0);
        HOST_REQ = 1'b0;
        step();
        chk("lock_done_pulse", {HOST_DONE, HOST_ERR}, 0);
        chk("lock_no_cs", cs_cnt - b_cs, 0);
        chk("lock_no_prog", pg_cnt - b_pg, 0);
        chk("lock_done_cnt", hd_cnt - b_hd, 1);

        // unlocked program
        PROG_UNLOCK = 1'b1;
        exp_addr = 6'h10;
        exp_dati = 8'h3C;
        snap();
        HOST_REQ = 1'b1;
        wait_done(1'b1, 1100, n);
        chk("prog_latency", n, 1005);
        chk("prog_err", HOST_ERR, 0);
        HOST_REQ = 1'b0;
        step();
        chk("prog_len", pg_cnt - b_pg, 1000);
        chk("prog_addr_data", bad_cnt - b_bad, 0);
        chk("prog_no_read", rd_cnt - b_rd, 0);
        chk("prog_done_cnt", hd_cnt - b_hd, 1);
        chk("prog_rdata_kept", HOST_RDATA, 0);

        // contention: boot first, host after one IDLE cycle
        snap();
        HOST_WR   = 1'b0;
        HOST_ADDR = 6'h05;
        BOOT_ADDR = 6'h07;
        BOOT_REQ  = 1'b1;
        HOST_REQ  = 1'b1;
        wait_done(1'b0, 20, n);
        chk("cont_boot_latency", n, 9);
        chk("cont_boot_rdata", BOOT_RDATA, 8'h77);
        chk("cont_host_waiting", {HOST_DONE, BUSY}, 0);
        BOOT_REQ = 1'b0;
        step();
        chk("cont_host_start", {BUSY, OTP_CS}, 2'b11);
        wait_done(1'b1, 20, n);
        chk("cont_host_latency", n, 8);
        chk("cont_host_rdata", HOST_RDATA, 8'h5A);
        chk("cont_boot_rdata_kept", BOOT_RDATA, 8'h77);
        HOST_REQ = 1'b0;
        step();
        chk("cont_boot_done_cnt", bd_cnt - b_bd, 1);
        chk("cont_host_done_cnt", hd_cnt - b_hd, 1);
        chk("cont_read_len", rd_cnt - b_rd, 8);

        // request dropped during STROBE
        snap();
        HOST_ADDR = 6'h21;
        HOST_REQ  = 1'b1;
        step();
        step();
        step();
        chk("drop_in_strobe", OTP_READ, 1);
        HOST_REQ = 1'b0;
        wait_done(1'b1, 20, n);
        chk("drop_latency", n, 6);
        chk("drop_rdata", HOST_RDATA, 8'hC3);
        step();
        chk("drop_done_pulse", HOST_DONE, 0);
        chk("drop_read_len", rd_cnt - b_rd, 4);
        chk("drop_done_cnt", hd_cnt - b_hd, 1);

        // reset in cycle 500 of a program
        HOST_WR    = 1'b1;
        HOST_ADDR  = 6'h2A;
        HOST_WDATA = 8'h55;
        exp_addr   = 6'h2A;
        exp_dati   = 8'h55;
        snap();
        HOST_REQ = 1'b1;
        repeat (502) step();
        chk("rstmid_prog_on", {OTP_PROG, OTP_CS}, 2'b11);
        #2;
        RESET = 1'b0;
        #1;
        chk("rstmid_async_drop", {OTP_PROG, OTP_CS, OTP_READ}, 0);
        chk("rstmid_busy", BUSY, 0);
        HOST_REQ = 1'b0;
        step();
        step();
        RESET = 1'b1;
        step();
        step();
        chk("rstmid_after_release", {BUSY, OTP_CS, OTP_PROG}, 0);
        chk("rstmid_no_done", hd_cnt - b_hd, 0);
        chk("strobes_exclusive", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
